// File: rtl/gcd_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// gcd_pkg : shared types and helpers for the GCD operand queue. Rev 1.0
// ------------------------------------------------------------------
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } opq_state_t;

  localparam int GCD_WL_DEFAULT = 8;

  // Pointer width carries one extra MSB used as the wrap flag.
  function automatic int opq_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gcd_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// gcd_fifo : DEPTH-entry FIFO with wrap-flag pointers. Rev 1.0
// ------------------------------------------------------------------
module gcd_fifo
  import gcd_pkg::*;
#(
  parameter int WL2   = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WL2-1:0]         wdata,
  input  logic                   pop,
  output logic [WL2-1:0]         rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = opq_ptr_w(DEPTH);
  localparam int IW = PW - 1;

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [WL2-1:0] mem_q [DEPTH];
  logic           do_push;
  logic           do_pop;

  assign full  = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign level = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[IW-1:0]];

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; emptiness is tracked solely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[IW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/gcd_operand_queue.sv
`default_nettype none
// ------------------------------------------------------------------
// gcd_operand_queue : buffers operand pairs and issues them to the GCD
// engine one at a time. Optional zero-pair discard: GCD_OPQ_ZERO_SKIP_EN.
// Rev 1.0
// ------------------------------------------------------------------
module gcd_operand_queue
  import gcd_pkg::*;
#(
  parameter int WL    = GCD_WL_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WL-1:0]          in_a,
  input  logic [WL-1:0]          in_b,
  output logic [WL-1:0]          op_a,
  output logic [WL-1:0]          op_b,
  output logic                   start,
  input  logic                   gcd_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   skip
);

  opq_state_t     state_q, state_d;
  logic [WL-1:0]  op_a_q, op_a_d;
  logic [WL-1:0]  op_b_q, op_b_d;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_pop;
  logic           push;
  logic [2*WL-1:0] head;
  logic [WL-1:0]  head_a;
  logic [WL-1:0]  head_b;
  logic           head_zero;

  // in_ready depends only on registered fullness, never on this cycle's pop.
  assign in_ready = ~rst & ~fifo_full;
  assign push     = in_valid & in_ready;
  assign {head_a, head_b} = head;

  gcd_fifo #(
    .WL2   (2 * WL),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({in_a, in_b}),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

`ifdef GCD_OPQ_ZERO_SKIP_EN
  // A zero operand would never terminate the subtract loop.
  assign head_zero = (head_a == '0) || (head_b == '0);
`else
  assign head_zero = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    fifo_pop = 1'b0;
    skip     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_zero) begin
            skip = 1'b1;
          end else begin
            op_a_d  = head_a;
            op_b_d  = head_b;
            state_d = START;
          end
        end
      end
      START:   state_d = BUSY;
      BUSY:    if (gcd_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

  assign op_a  = op_a_q;
  assign op_b  = op_b_q;
  assign start = (state_q == START);
  assign busy  = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gcd_operand_queue.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_gcd_operand_queue : directed scoreboard bench for gcd_operand_queue.
// Rev 1.0
// ------------------------------------------------------------------
module tb_gcd_operand_queue;

  localparam int WL    = 8;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [WL-1:0] in_a;
  logic [WL-1:0] in_b;
  logic [WL-1:0] op_a;
  logic [WL-1:0] op_b;
  logic          start;
  logic          gcd_done;
  logic          busy;
  logic [2:0]    level;
  logic          skip;

  int n_cmp;
  int n_bad;
  int start_cnt;
  int skip_cnt;
  logic [2*WL-1:0] sb[$];
  logic [2*WL-1:0] exp_pair;

  gcd_operand_queue #(.WL(WL), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .op_a     (op_a),
    .op_b     (op_b),
    .start    (start),
    .gcd_done (gcd_done),
    .busy     (busy),
    .level    (level),
    .skip     (skip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every start pulse must present the oldest expected pair.
  always @(negedge clk) begin
    if (!rst && skip) skip_cnt++;
    if (!rst && start) begin
      start_cnt++;
      if (sb.size() == 0) begin
        check("start_unexpected", 1, 0);
      end else begin
        exp_pair = sb.pop_front();
        check("issue_op_a", op_a, exp_pair[2*WL-1:WL]);
        check("issue_op_b", op_b, exp_pair[WL-1:0]);
        check("issue_busy", busy, 1);
      end
    end
  end

  task automatic push_pair(input logic [WL-1:0] a, input logic [WL-1:0] b, input bit issued);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      check("push_ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    if (issued) sb.push_back({a, b});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic finish_one();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(busy && !start) && t < 50);
    if (!(busy && !start)) begin
      check("busy_wait_timeout", 0, 1);
      return;
    end
    gcd_done = 1'b1;
    @(posedge clk); #1;
    gcd_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0; start_cnt = 0; skip_cnt = 0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; gcd_done = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_level", level, 0);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_skip", skip, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Single pair latency
    push_pair(8'd48, 8'd18, 1'b1);
    check("t1_level_after_push", level, 1);
    check("t1_idle_busy", busy, 0);
    check("t1_no_start_yet", start, 0);
    @(posedge clk); #1;
    check("t1_start", start, 1);
    check("t1_level_after_pop", level, 0);
    @(posedge clk); #1;
    check("t1_start_one_cycle", start, 0);
    check("t1_busy_held", busy, 1);
    finish_one();
    check("t1_busy_cleared", busy, 0);

    // Fill to full while the engine stalls
    push_pair(8'd10, 8'd4, 1'b1);
    push_pair(8'd21, 8'd14, 1'b1);
    push_pair(8'd35, 8'd15, 1'b1);
    push_pair(8'd9, 8'd6, 1'b1);
    push_pair(8'd100, 8'd75, 1'b1);
    check("t2_level_full", level, 4);
    check("t2_in_ready_full", in_ready, 0);
    in_valid = 1'b1; in_a = 8'd77; in_b = 8'd11;
    repeat (3) begin @(posedge clk); #1; end
    check("t2_sixth_rejected_level", level, 4);
    check("t2_sixth_rejected_ready", in_ready, 0);
    in_valid = 1'b0;
    repeat (5) finish_one();
    check("t2_drained_level", level, 0);

    // Simultaneous push and pop, across pointer wrap
    push_pair(8'd30, 8'd12, 1'b1);
    push_pair(8'd27, 8'd9, 1'b1);
    push_pair(8'd64, 8'd16, 1'b1);
    check("t3_level_two", level, 2);
    finish_one();
    push_pair(8'd50, 8'd20, 1'b1);
    check("t3_level_push_pop", level, 2);
    check("t3_start_on_pop", start, 1);
    repeat (3) finish_one();
    check("t3_drained_level", level, 0);

    // gcd_done in IDLE and START is ignored; in BUSY it returns to IDLE
    gcd_done = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    gcd_done = 1'b0;
    check("t4_idle_done_busy", busy, 0);
    check("t4_idle_done_level", level, 0);
    push_pair(8'd81, 8'd27, 1'b1);
    gcd_done = 1'b1;
    @(posedge clk); #1;
    check("t4_start_with_done", start, 1);
    @(posedge clk); #1;
    gcd_done = 1'b0;
    check("t4_done_in_start_ignored", busy, 1);
    gcd_done = 1'b1;
    @(posedge clk); #1;
    gcd_done = 1'b0;
    check("t4_done_in_busy", busy, 0);

    // Reset while busy with three pairs queued
    push_pair(8'd44, 8'd33, 1'b1);
    push_pair(8'd15, 8'd5, 1'b1);
    push_pair(8'd8, 8'd2, 1'b1);
    push_pair(8'd91, 8'd13, 1'b1);
    check("t5_level_three", level, 3);
    check("t5_busy", busy, 1);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("t5_rst_start", start, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_level", level, 0);
    check("t5_rst_op_a", op_a, 0);
    check("t5_rst_op_b", op_b, 0);
    check("t5_rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_pair(8'd18, 8'd12, 1'b1);
    finish_one();
    check("t5_after_rst_level", level, 0);

    // Zero-operand pair
`ifdef GCD_OPQ_ZERO_SKIP_EN
    push_pair(8'd0, 8'd7, 1'b0);
    push_pair(8'd12, 8'd8, 1'b1);
    finish_one();
`else
    push_pair(8'd0, 8'd7, 1'b1);
    push_pair(8'd12, 8'd8, 1'b1);
    repeat (2) finish_one();
`endif

    repeat (5) begin @(posedge clk); #1; end
    check("end_scoreboard_empty", sb.size(), 0);
    check("end_level", level, 0);
`ifdef GCD_OPQ_ZERO_SKIP_EN
    check("end_skip_count", skip_cnt, 1);
    check("end_start_count", start_cnt, 14);
`else
    check("end_skip_count", skip_cnt, 0);
    check("end_start_count", start_cnt, 15);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
